// File: rtl/rv32i_bus_arbiter_if.sv
// Bundle of the core load/store bus, the external requester handshake and the
// shared data-memory port. The arbiter takes the slave view; core, external agent and RAM take the master view.
interface rv32i_bus_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] core_addr;
  logic [DATA_WIDTH-1:0] core_wrdata;
  logic                  core_wren;
  logic                  core_rden;
  logic [DATA_WIDTH-1:0] core_rddata;
  logic                  core_stall;

  logic                  ext_req;
  logic                  ext_we;
  logic [DATA_WIDTH-1:0] ext_addr;
  logic [DATA_WIDTH-1:0] ext_wrdata;
  logic                  ext_gnt;
  logic                  ext_done;
  logic [DATA_WIDTH-1:0] ext_rddata;

  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wrdata;
  logic                  mem_wren;
  logic                  mem_rden;
  logic [DATA_WIDTH-1:0] mem_rddata;

  modport slave (
    input  core_addr, core_wrdata, core_wren, core_rden,
    output core_rddata, core_stall,
    input  ext_req, ext_we, ext_addr, ext_wrdata,
    output ext_gnt, ext_done, ext_rddata,
    output mem_addr, mem_wrdata, mem_wren, mem_rden,
    input  mem_rddata
  );

  modport master (
    output core_addr, core_wrdata, core_wren, core_rden,
    input  core_rddata, core_stall,
    output ext_req, ext_we, ext_addr, ext_wrdata,
    input  ext_gnt, ext_done, ext_rddata,
    input  mem_addr, mem_wrdata, mem_wren, mem_rden,
    output mem_rddata
  );
endinterface

// File: rtl/rv32i_bus_arbiter.sv
// Round-robin arbiter sharing one fixed-latency data-memory port between the RV32I core and an external requester.
// Define RV32I_BUS_ARB_PERF_CNT_EN to add the stall_cycles / ext_accesses performance counters.
module rv32i_bus_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  rv32i_bus_arbiter_if.slave bus
`ifdef RV32I_BUS_ARB_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [15:0]        ext_accesses
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  localparam logic       OWN_CORE = 1'b0;
  localparam logic       OWN_EXT  = 1'b1;
  localparam logic [3:0] LAT      = 4'(MEM_LATENCY);

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_owner_q, last_owner_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_WIDTH-1:0] ext_rdata_q, ext_rdata_d;
  logic [3:0]            cnt_q, cnt_d;

  logic core_req;
  logic core_resp;
  logic ext_gnt_c, ext_done_c, mem_wren_c, mem_rden_c;
  logic ext_done_o;

  assign core_req = bus.core_wren | bus.core_rden;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    core_rdata_d = core_rdata_q;
    ext_rdata_d  = ext_rdata_q;
    cnt_d        = cnt_q;
    core_resp    = 1'b0;
    ext_gnt_c    = 1'b0;
    ext_done_c   = 1'b0;
    mem_wren_c   = 1'b0;
    mem_rden_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // On contention the requester that was not served last wins.
        if (core_req && (!bus.ext_req || last_owner_q == OWN_EXT)) begin
          owner_d = OWN_CORE;
          addr_d  = bus.core_addr;
          wdata_d = bus.core_wrdata;
          we_d    = bus.core_wren;
          state_d = S_ACCESS;
        end else if (bus.ext_req) begin
          owner_d   = OWN_EXT;
          addr_d    = bus.ext_addr;
          wdata_d   = bus.ext_wrdata;
          we_d      = bus.ext_we;
          ext_gnt_c = 1'b1;
          state_d   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_wren_c = we_q;
        mem_rden_c = ~we_q;
        cnt_d      = LAT;
        state_d    = (MEM_LATENCY > 0) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        last_owner_d = owner_q;
        state_d      = S_IDLE;
        if (owner_q == OWN_CORE) begin
          core_resp    = 1'b1;
          core_rdata_d = we_q ? '0 : bus.mem_rddata;
        end else begin
          ext_done_c = 1'b1;
          if (!we_q) ext_rdata_d = bus.mem_rddata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_CORE;
      last_owner_q <= OWN_EXT;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_rdata_q <= '0;
      ext_rdata_q  <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_rdata_q <= core_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
      cnt_q        <= cnt_d;
    end
  end

  // Response data is bypassed so the owner sees it in the RESP cycle itself.
  assign ext_done_o      = ext_done_c & ~rst;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wrdata  = wdata_q;
  assign bus.mem_wren    = mem_wren_c & ~rst;
  assign bus.mem_rden    = mem_rden_c & ~rst;
  assign bus.ext_gnt     = ext_gnt_c & ~rst;
  assign bus.ext_done    = ext_done_o;
  assign bus.ext_rddata  = ext_done_o ? ext_rdata_d : ext_rdata_q;
  assign bus.core_stall  = ~rst & core_req & ~core_resp;
  assign bus.core_rddata = core_resp ? core_rdata_d : core_rdata_q;

`ifdef RV32I_BUS_ARB_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] ext_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      ext_cnt_q   <= '0;
    end else begin
      if (bus.core_stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ext_done_o && ext_cnt_q != '1)       ext_cnt_q   <= ext_cnt_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign ext_accesses = ext_cnt_q;
`endif

endmodule

// File: tb/tb_rv32i_bus_arbiter.sv
// Directed bench for rv32i_bus_arbiter: three instances at MEM_LATENCY 1, 0 and 2 sharing one behavioural RAM.
module tb_rv32i_bus_arbiter;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  rv32i_bus_arbiter_if #(.DATA_WIDTH(DW)) bus0 ();
  rv32i_bus_arbiter_if #(.DATA_WIDTH(DW)) bus1 ();
  rv32i_bus_arbiter_if #(.DATA_WIDTH(DW)) bus2 ();

`ifdef RV32I_BUS_ARB_PERF_CNT_EN
  logic [31:0] sc0, sc1, sc2;
  logic [15:0] ea0, ea1, ea2;
`endif

  rv32i_bus_arbiter #(.DATA_WIDTH(DW), .MEM_LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .bus(bus0)
`ifdef RV32I_BUS_ARB_PERF_CNT_EN
    , .stall_cycles(sc0), .ext_accesses(ea0)
`endif
  );
  rv32i_bus_arbiter #(.DATA_WIDTH(DW), .MEM_LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst), .bus(bus1)
`ifdef RV32I_BUS_ARB_PERF_CNT_EN
    , .stall_cycles(sc1), .ext_accesses(ea1)
`endif
  );
  rv32i_bus_arbiter #(.DATA_WIDTH(DW), .MEM_LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .bus(bus2)
`ifdef RV32I_BUS_ARB_PERF_CNT_EN
    , .stall_cycles(sc2), .ext_accesses(ea2)
`endif
  );

  assign bus0.mem_rddata = mem[bus0.mem_addr[9:2]];
  assign bus1.mem_rddata = mem[bus1.mem_addr[9:2]];
  assign bus2.mem_rddata = mem[bus2.mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC000_0000 | 32'(i);
      mem[16] <= 32'hDEADBEEF;
    end else begin
      if (bus0.mem_wren) mem[bus0.mem_addr[9:2]] <= bus0.mem_wrdata;
      if (bus1.mem_wren) mem[bus1.mem_addr[9:2]] <= bus1.mem_wrdata;
      if (bus2.mem_wren) mem[bus2.mem_addr[9:2]] <= bus2.mem_wrdata;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus0.core_addr = '0; bus0.core_wrdata = '0; bus0.core_wren = 0; bus0.core_rden = 0;
    bus0.ext_req = 0; bus0.ext_we = 0; bus0.ext_addr = '0; bus0.ext_wrdata = '0;
    bus1.core_addr = '0; bus1.core_wrdata = '0; bus1.core_wren = 0; bus1.core_rden = 0;
    bus1.ext_req = 0; bus1.ext_we = 0; bus1.ext_addr = '0; bus1.ext_wrdata = '0;
    bus2.core_addr = '0; bus2.core_wrdata = '0; bus2.core_wren = 0; bus2.core_rden = 0;
    bus2.ext_req = 0; bus2.ext_we = 0; bus2.ext_addr = '0; bus2.ext_wrdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_init = 1'b1;
    clear_inputs();
    bus0.core_rden = 1'b1;
    repeat (2) cyc();
    mem_init = 1'b0;
    smp();
    checks++; if (bus0.core_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus0.core_stall); end
    checks++; if (bus0.mem_rden !== 1'b0) begin failures++; $display("FAIL reset_rden got=%b exp=0", bus0.mem_rden); end
    checks++; if (bus0.mem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus0.mem_addr); end
    checks++; if (bus0.ext_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", bus0.ext_gnt); end
    checks++; if (bus0.core_rddata !== 32'h0) begin failures++; $display("FAIL reset_core_rd got=%h exp=0", bus0.core_rddata); end
    checks++; if (bus0.ext_rddata !== 32'h0) begin failures++; $display("FAIL reset_ext_rd got=%h exp=0", bus0.ext_rddata); end
    cyc();
    rst = 1'b0;
    bus0.core_rden = 1'b0;
  endtask

  task automatic test_core_load();
    logic [3:0] exp_stall, exp_rden;
    exp_stall = 4'b0111;
    exp_rden  = 4'b0010;
    cyc();
    bus0.core_rden = 1'b1; bus0.core_addr = 32'h40;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) cyc();
      smp();
      checks++; if (bus0.core_stall !== exp_stall[c]) begin failures++; $display("FAIL core_load_stall c=%0d got=%b exp=%b", c, bus0.core_stall, exp_stall[c]); end
      checks++; if (bus0.mem_rden !== exp_rden[c]) begin failures++; $display("FAIL core_load_rden c=%0d got=%b exp=%b", c, bus0.mem_rden, exp_rden[c]); end
      if (c == 1) begin
        checks++; if (bus0.mem_addr !== 32'h40) begin failures++; $display("FAIL core_load_addr got=%h exp=40", bus0.mem_addr); end
      end
      if (c == 3) begin
        checks++; if (bus0.core_rddata !== 32'hDEADBEEF) begin failures++; $display("FAIL core_load_data got=%h exp=deadbeef", bus0.core_rddata); end
      end
    end
    cyc();
    bus0.core_rden = 1'b0;
    smp();
    checks++; if (bus0.core_stall !== 1'b0) begin failures++; $display("FAIL core_idle_stall got=%b exp=0", bus0.core_stall); end
    checks++; if (bus0.core_rddata !== 32'hDEADBEEF) begin failures++; $display("FAIL core_data_hold got=%h exp=deadbeef", bus0.core_rddata); end
  endtask

  task automatic test_ext_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp_rd);
    logic eg, ed, ew, er;
    cyc();
    bus0.ext_req = 1'b1; bus0.ext_we = we; bus0.ext_addr = addr; bus0.ext_wrdata = wdata;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) cyc();
      smp();
      eg = (c == 0);
      ed = (c == 3);
      ew = (c == 1) && we;
      er = (c == 1) && !we;
      checks++; if (bus0.ext_gnt !== eg) begin failures++; $display("FAIL ext_gnt we=%b c=%0d got=%b exp=%b", we, c, bus0.ext_gnt, eg); end
      checks++; if (bus0.ext_done !== ed) begin failures++; $display("FAIL ext_done we=%b c=%0d got=%b exp=%b", we, c, bus0.ext_done, ed); end
      checks++; if (bus0.mem_wren !== ew) begin failures++; $display("FAIL ext_wren we=%b c=%0d got=%b exp=%b", we, c, bus0.mem_wren, ew); end
      checks++; if (bus0.mem_rden !== er) begin failures++; $display("FAIL ext_rden we=%b c=%0d got=%b exp=%b", we, c, bus0.mem_rden, er); end
      checks++; if (bus0.core_stall !== 1'b0) begin failures++; $display("FAIL ext_core_stall c=%0d got=%b exp=0", c, bus0.core_stall); end
      if (c == 1) begin
        checks++; if (bus0.mem_addr !== addr) begin failures++; $display("FAIL ext_addr got=%h exp=%h", bus0.mem_addr, addr); end
        if (we) begin
          checks++; if (bus0.mem_wrdata !== wdata) begin failures++; $display("FAIL ext_wrdata got=%h exp=%h", bus0.mem_wrdata, wdata); end
        end
      end
      if (c == 3 && !we) begin
        checks++; if (bus0.ext_rddata !== exp_rd) begin failures++; $display("FAIL ext_rddata got=%h exp=%h", bus0.ext_rddata, exp_rd); end
      end
    end
    cyc();
    bus0.ext_req = 1'b0;
    smp();
    checks++; if (bus0.ext_done !== 1'b0) begin failures++; $display("FAIL ext_done_after got=%b exp=0", bus0.ext_done); end
    if (!we) begin
      checks++; if (bus0.ext_rddata !== exp_rd) begin failures++; $display("FAIL ext_rddata_hold got=%h exp=%h", bus0.ext_rddata, exp_rd); end
    end
  endtask

  task automatic test_contention();
    logic [11:0] t_stall, t_gnt, t_done, t_wren, t_rden;
    t_stall = 12'b0111_1111_0111;
    t_gnt   = 12'h010;
    t_done  = 12'h080;
    t_wren  = 12'h202;
    t_rden  = 12'h020;
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    cyc();
    bus0.core_wren = 1'b1; bus0.core_addr = 32'h100; bus0.core_wrdata = 32'hA5A5A5A5;
    bus0.ext_req = 1'b1; bus0.ext_we = 1'b0; bus0.ext_addr = 32'h40;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) cyc();
      if (c == 4) begin bus0.core_addr = 32'h104; bus0.core_wrdata = 32'h5A5A5A5A; end
      if (c == 8) bus0.ext_req = 1'b0;
      smp();
      checks++; if (bus0.core_stall !== t_stall[c]) begin failures++; $display("FAIL cont_stall c=%0d got=%b exp=%b", c, bus0.core_stall, t_stall[c]); end
      checks++; if (bus0.ext_gnt !== t_gnt[c]) begin failures++; $display("FAIL cont_gnt c=%0d got=%b exp=%b", c, bus0.ext_gnt, t_gnt[c]); end
      checks++; if (bus0.ext_done !== t_done[c]) begin failures++; $display("FAIL cont_done c=%0d got=%b exp=%b", c, bus0.ext_done, t_done[c]); end
      checks++; if (bus0.mem_wren !== t_wren[c]) begin failures++; $display("FAIL cont_wren c=%0d got=%b exp=%b", c, bus0.mem_wren, t_wren[c]); end
      checks++; if (bus0.mem_rden !== t_rden[c]) begin failures++; $display("FAIL cont_rden c=%0d got=%b exp=%b", c, bus0.mem_rden, t_rden[c]); end
      if (c == 1) begin checks++; if (bus0.mem_addr !== 32'h100) begin failures++; $display("FAIL cont_addr1 got=%h exp=100", bus0.mem_addr); end end
      if (c == 5) begin checks++; if (bus0.mem_addr !== 32'h40) begin failures++; $display("FAIL cont_addr5 got=%h exp=40", bus0.mem_addr); end end
      if (c == 9) begin checks++; if (bus0.mem_addr !== 32'h104) begin failures++; $display("FAIL cont_addr9 got=%h exp=104", bus0.mem_addr); end end
      if (c == 3) begin checks++; if (bus0.core_rddata !== 32'h0) begin failures++; $display("FAIL cont_store_rd got=%h exp=0", bus0.core_rddata); end end
      if (c == 7) begin checks++; if (bus0.ext_rddata !== 32'hDEADBEEF) begin failures++; $display("FAIL cont_ext_rd got=%h exp=deadbeef", bus0.ext_rddata); end end
    end
    cyc();
    bus0.core_wren = 1'b0;
    smp();
    checks++; if (mem[64] !== 32'hA5A5A5A5) begin failures++; $display("FAIL cont_mem100 got=%h exp=a5a5a5a5", mem[64]); end
    checks++; if (mem[65] !== 32'h5A5A5A5A) begin failures++; $display("FAIL cont_mem104 got=%h exp=5a5a5a5a", mem[65]); end
  endtask

  task automatic test_withdraw();
    logic [3:0] b_done;
    b_done = 4'b1000;
    // External request appears and vanishes while the core owns the bus.
    cyc();
    bus0.core_rden = 1'b1; bus0.core_addr = 32'h40;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) cyc();
      if (c == 1) begin bus0.ext_req = 1'b1; bus0.ext_we = 1'b0; bus0.ext_addr = 32'h80; end
      if (c == 2) bus0.ext_req = 1'b0;
      if (c == 4) bus0.core_rden = 1'b0;
      smp();
      checks++; if (bus0.ext_gnt !== 1'b0) begin failures++; $display("FAIL wd_gnt c=%0d got=%b exp=0", c, bus0.ext_gnt); end
      checks++; if (bus0.ext_done !== 1'b0) begin failures++; $display("FAIL wd_done c=%0d got=%b exp=0", c, bus0.ext_done); end
    end
    // Request dropped right after grant still completes.
    cyc();
    bus0.ext_req = 1'b1; bus0.ext_we = 1'b0; bus0.ext_addr = 32'h80;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) cyc();
      if (c == 1) bus0.ext_req = 1'b0;
      smp();
      checks++; if (bus0.ext_done !== b_done[c]) begin failures++; $display("FAIL late_drop_done c=%0d got=%b exp=%b", c, bus0.ext_done, b_done[c]); end
      if (c == 3) begin
        checks++; if (bus0.ext_rddata !== 32'h12345678) begin failures++; $display("FAIL late_drop_data got=%h exp=12345678", bus0.ext_rddata); end
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc();
    bus0.ext_req = 1'b1; bus0.ext_we = 1'b0; bus0.ext_addr = 32'h104;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    bus0.ext_req = 1'b0;
    smp();
    checks++; if (bus0.ext_done !== 1'b0) begin failures++; $display("FAIL rmid_done got=%b exp=0", bus0.ext_done); end
    checks++; if (bus0.ext_gnt !== 1'b0) begin failures++; $display("FAIL rmid_gnt got=%b exp=0", bus0.ext_gnt); end
    checks++; if (bus0.mem_rden !== 1'b0) begin failures++; $display("FAIL rmid_rden got=%b exp=0", bus0.mem_rden); end
    checks++; if (bus0.mem_addr !== 32'h0) begin failures++; $display("FAIL rmid_addr got=%h exp=0", bus0.mem_addr); end
    checks++; if (bus0.mem_wrdata !== 32'h0) begin failures++; $display("FAIL rmid_wrdata got=%h exp=0", bus0.mem_wrdata); end
    checks++; if (bus0.ext_rddata !== 32'h0) begin failures++; $display("FAIL rmid_ext_rd got=%h exp=0", bus0.ext_rddata); end
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) cyc();
      smp();
      checks++; if (bus0.ext_done !== 1'b0) begin failures++; $display("FAIL rmid_no_done c=%0d got=%b exp=0", c, bus0.ext_done); end
    end
    test_ext_access(1'b0, 32'h104, 32'h0, 32'h5A5A5A5A);
  endtask

  task automatic test_lat0();
    logic [2:0] e_stall, e_rden, e_done;
    e_stall = 3'b011;
    e_rden  = 3'b010;
    e_done  = 3'b100;
    cyc();
    bus1.core_rden = 1'b1; bus1.core_addr = 32'h40;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) cyc();
      smp();
      checks++; if (bus1.core_stall !== e_stall[c]) begin failures++; $display("FAIL lat0_stall c=%0d got=%b exp=%b", c, bus1.core_stall, e_stall[c]); end
      checks++; if (bus1.mem_rden !== e_rden[c]) begin failures++; $display("FAIL lat0_rden c=%0d got=%b exp=%b", c, bus1.mem_rden, e_rden[c]); end
      if (c == 2) begin
        checks++; if (bus1.core_rddata !== 32'hDEADBEEF) begin failures++; $display("FAIL lat0_data got=%h exp=deadbeef", bus1.core_rddata); end
      end
    end
    cyc();
    bus1.core_rden = 1'b0;
    bus1.ext_req = 1'b1; bus1.ext_we = 1'b0; bus1.ext_addr = 32'h100;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) cyc();
      smp();
      checks++; if (bus1.ext_done !== e_done[c]) begin failures++; $display("FAIL lat0_ext_done c=%0d got=%b exp=%b", c, bus1.ext_done, e_done[c]); end
      if (c == 2) begin
        checks++; if (bus1.ext_rddata !== 32'hA5A5A5A5) begin failures++; $display("FAIL lat0_ext_data got=%h exp=a5a5a5a5", bus1.ext_rddata); end
      end
    end
    cyc();
    bus1.ext_req = 1'b0;
  endtask

  task automatic test_both_strobes();
    logic [4:0] e_stall, e_wren;
    e_stall = 5'b01111;
    e_wren  = 5'b00010;
    cyc();
    bus2.core_wren = 1'b1; bus2.core_rden = 1'b1;
    bus2.core_addr = 32'h200; bus2.core_wrdata = 32'hCAFEF00D;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) cyc();
      smp();
      checks++; if (bus2.core_stall !== e_stall[c]) begin failures++; $display("FAIL both_stall c=%0d got=%b exp=%b", c, bus2.core_stall, e_stall[c]); end
      checks++; if (bus2.mem_wren !== e_wren[c]) begin failures++; $display("FAIL both_wren c=%0d got=%b exp=%b", c, bus2.mem_wren, e_wren[c]); end
      checks++; if (bus2.mem_rden !== 1'b0) begin failures++; $display("FAIL both_rden c=%0d got=%b exp=0", c, bus2.mem_rden); end
      if (c == 4) begin
        checks++; if (bus2.core_rddata !== 32'h0) begin failures++; $display("FAIL both_rddata got=%h exp=0", bus2.core_rddata); end
      end
    end
    cyc();
    bus2.core_wren = 1'b0; bus2.core_rden = 1'b0;
    smp();
    checks++; if (mem[128] !== 32'hCAFEF00D) begin failures++; $display("FAIL both_mem got=%h exp=cafef00d", mem[128]); end
  endtask

`ifdef RV32I_BUS_ARB_PERF_CNT_EN
  task automatic test_perf_counters();
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    // Two solo loads: 4 stall cycles each.
    for (int k = 0; k < 2; k++) begin
      cyc();
      bus2.core_rden = 1'b1; bus2.core_addr = 32'h40;
      repeat (4) cyc();
      cyc();
      bus2.core_rden = 1'b0;
    end
    // Third load contends with an external read and loses (core served last): 5 + 4 stall cycles.
    cyc();
    bus2.core_rden = 1'b1; bus2.ext_req = 1'b1; bus2.ext_we = 1'b0; bus2.ext_addr = 32'h80;
    repeat (4) cyc();
    cyc();
    bus2.ext_req = 1'b0;
    repeat (4) cyc();
    cyc();
    bus2.core_rden = 1'b0;
    // Solo external write: no core stall.
    cyc();
    bus2.ext_req = 1'b1; bus2.ext_we = 1'b1; bus2.ext_addr = 32'h84; bus2.ext_wrdata = 32'h1;
    repeat (3) cyc();
    cyc();
    bus2.ext_req = 1'b0;
    cyc();
    smp();
    checks++; if (sc2 !== 32'd17) begin failures++; $display("FAIL perf_stall got=%0d exp=17", sc2); end
    checks++; if (ea2 !== 16'd2) begin failures++; $display("FAIL perf_ext got=%0d exp=2", ea2); end
  endtask
`endif

  initial begin
    test_reset();
    test_core_load();
    test_ext_access(1'b1, 32'h80, 32'h12345678, 32'h0);
    test_ext_access(1'b0, 32'h80, 32'h0, 32'h12345678);
    test_contention();
    test_withdraw();
    test_reset_mid();
    test_lat0();
    test_both_strobes();
`ifdef RV32I_BUS_ARB_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/rv32i_bus_arbiter.md
Name: rv32i_bus_arbiter

Overview:
- Shares the single data-memory port between two requesters: the RV32I single-cycle core's load/store interface, and an external requester such as a debug/UART loader or DMA.
- Sequences each access through a fixed-latency memory and stalls the core until its access completes.
- Uses round-robin arbitration when both requesters contend.
- Sits between RV32I_core (bus_addr/bus_wrdata/bus_wren/bus_rden/bus_rddata) and the data RAM.

Parameters:
- DATA_WIDTH, 32, width of the data and address buses.
- MEM_LATENCY, 1, cycles from the memory strobe to valid mem_rddata. Legal range 0..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- core_addr  in  DATA_WIDTH  core bus_addr.
- core_wrdata  in  DATA_WIDTH  core bus_wrdata.
- core_wren  in  1  core store request.
- core_rden  in  1  core load request.
- core_rddata  out  DATA_WIDTH  load data to the core; valid while core_stall=0 in the RESP cycle.
- core_stall  out  1  freezes the core's PC and register-file write while its access is pending.
- ext_req  in  1  external request. Held high, with fields stable, until ext_done.
- ext_we  in  1  1 = write, 0 = read.
- ext_addr  in  DATA_WIDTH  external address.
- ext_wrdata  in  DATA_WIDTH  external write data.
- ext_gnt  out  1  one-cycle pulse when the external request is accepted.
- ext_done  out  1  one-cycle pulse when the external access completes.
- ext_rddata  out  DATA_WIDTH  external read data; valid while ext_done=1, held afterwards.
- mem_addr  out  DATA_WIDTH  memory address.
- mem_wrdata  out  DATA_WIDTH  memory write data.
- mem_wren  out  1  memory write strobe.
- mem_rden  out  1  memory read strobe.
- mem_rddata  in  DATA_WIDTH  memory read data.

Behaviour:
- Core request is core_wren|core_rden. If both are high, the access is a write and core_rddata returns 0.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Neither requesting: stay.
  - One requesting: grant it.
  - Both requesting: grant the requester that is not last_owner.
  - On grant: latch owner, address, write data and we into registers, then go to ACCESS. ext_gnt pulses in this IDLE cycle when the external requester wins.
- ACCESS (exactly 1 cycle):
  - mem_addr and mem_wrdata driven from the latched registers; mem_wren or mem_rden = 1.
  - Load the latency counter with MEM_LATENCY.
  - Next state: WAIT if MEM_LATENCY>0, else RESP.
- WAIT: decrement the counter each cycle; go to RESP when the counter reaches 1. Strobes are 0.
- RESP (1 cycle):
  - Capture mem_rddata into the owner's read-data register. For writes, capture 0 (core) or leave unchanged (external).
  - Owner = core: core_stall=0 this cycle and core_rddata = mem_rddata (combinational bypass).
  - Owner = external: ext_done=1.
  - Update last_owner; go to IDLE.
- core_stall is combinational: 1 when a core request is present, except in RESP with owner=core; 0 while rst=1.
- Core access latency: stall spans IDLE, ACCESS, WAIT×MEM_LATENCY, then releases in RESP, i.e. 3+MEM_LATENCY cycles per access with the core frozen for 2+MEM_LATENCY of them.
- Non-memory instructions (no core request) never stall.
- ext_req dropped before grant: the request is withdrawn, no effect. Dropped after grant: the access still completes and ext_done still pulses.
- Back-to-back contention: after core is served, a pending external request wins the next IDLE, and vice versa. No requester is starved by more than one access.
- mem_addr and mem_wrdata hold their last values outside ACCESS; the strobes are 0.
- Reset, including mid-access:
  - State → IDLE; counter → 0; last_owner → EXT, so the core wins the first contention.
  - All registered outputs → 0: mem_addr, mem_wrdata, mem_wren, mem_rden, ext_gnt, ext_done, ext_rddata, core_rddata register.
  - An aborted access produces no ext_done and no data.

Optional Feature:
- Macro: RV32I_BUS_ARB_PERF_CNT_EN.
- Defined:
  - Adds output port stall_cycles (out, 32): counts clk cycles with core_stall=1.
  - Adds output port ext_accesses (out, 16): counts ext_done pulses.
  - Both counters saturate at all-ones and clear on rst.
- Undefined: the ports and counters are absent; no other behaviour changes.

Test Plan:
- Core load, MEM_LATENCY=1, core_rden=1, core_addr=0x40, memory returns 0xDEADBEEF → core_stall high for 3 cycles; core_rddata=0xDEADBEEF in RESP with stall=0; mem_rden pulses once at addr 0x40.
- External write, ext_req=1, ext_we=1, ext_addr=0x80, ext_wrdata=0x12345678 → ext_gnt on cycle 0; mem_wren=1 with 0x80/0x12345678 on cycle 1; ext_done on cycle 3; core_stall stays 0.
- Contention after reset: core_wren and ext_req asserted in the same cycle → core served first (last_owner=EXT); ext_gnt in the next IDLE; ext_done follows. Repeat both → external wins.
- MEM_LATENCY=0: core load → ACCESS→RESP with no WAIT; stall lasts 2 cycles; data correct.
- Reset mid-op: rst asserted during WAIT of an external read → next cycle IDLE with all outputs 0; no ext_done; a new request after reset completes normally.
- With RV32I_BUS_ARB_PERF_CNT_EN: 3 core loads at MEM_LATENCY=2 plus 2 external accesses → stall_cycles = 3×4 + the extra cycles spent waiting behind external accesses (checked by the model); ext_accesses=2.
